// File: rtl/mult_matrix_systolic.sv
// Weight-stationary systolic multiply-accumulate array computing y = x*W for a
// diagonally skewed activation stream. Column outputs are deskewed internally so
// all results of a vector leave together, qualified by out_valid.
module mult_matrix_systolic #(
    parameter int data_size = 4,
    parameter int size      = 3,
    parameter int acc_size  = 10
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [data_size*size-1:0]  input_stream,
    input  logic                       in_valid,
    input  logic                       weight_load,
    input  logic [data_size*size-1:0]  weight_row,
    output logic                       load_ready,
    output logic                       weights_ready,
    output logic [acc_size*size-1:0]   output_stream,
    output logic                       out_valid
);

    localparam int cnt_w    = (size > 1) ? $clog2(size) : 1;
    localparam int vp_depth = 2*size - 1;
    localparam logic [cnt_w-1:0] last_row = cnt_w'(size - 1);

    typedef enum logic [1:0] {EMPTY, PARTIAL, LOADED} load_state_t;

    load_state_t          state;
    logic [cnt_w-1:0]     row_cnt;
    logic [data_size-1:0] weight  [size][size];
    logic [data_size-1:0] a_in    [size][size];
    logic [data_size-1:0] a_reg   [size][size];
    logic [acc_size-1:0]  psum_in [size][size];
    logic [acc_size-1:0]  psum    [size][size];
    logic [acc_size-1:0]  col_out [size];
    logic [vp_depth-1:0]  valid_pipe;
    logic                 load_accept;
    logic                 vec_accept;

    // Weights may only change while nothing valid is in flight; a load wins over
    // a simultaneous vector, which is then dropped from the valid pipeline.
    assign load_ready  = (valid_pipe == '0);
    assign load_accept = weight_load && load_ready;
    assign vec_accept  = in_valid && weights_ready && !load_accept;
    assign out_valid   = valid_pipe[vp_depth-1];

    // Weight-load FSM: write the addressed row and track whether a full set is present.
    // NOTE: all clocked state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= EMPTY;
            row_cnt       <= '0;
            weights_ready <= 1'b0;
            // NOTE: the weight store is flops, not RAM, and is cleared on reset so a
            // partially reloaded set never mixes with rows from before the reset.
            for (int r = 0; r < size; r++) begin
                for (int c = 0; c < size; c++) begin
                    weight[r][c] <= '0;
                end
            end
        end else if (load_accept) begin
            for (int c = 0; c < size; c++) begin
                weight[row_cnt][c] <= weight_row[(size-c)*data_size-1 -: data_size];
            end
            row_cnt <= (row_cnt == last_row) ? '0 : row_cnt + 1'b1;
            case (state)
                EMPTY, LOADED: begin
                    if (row_cnt == last_row) begin
                        state         <= LOADED;
                        weights_ready <= 1'b1;
                    end else begin
                        state         <= PARTIAL;
                        weights_ready <= 1'b0;
                    end
                end
                PARTIAL: begin
                    if (row_cnt == last_row) begin
                        state         <= LOADED;
                        weights_ready <= 1'b1;
                    end
                end
                default: begin
                    state         <= EMPTY;
                    weights_ready <= 1'b0;
                end
            endcase
        end
    end

    for (genvar r = 0; r < size; r++) begin : g_row
        for (genvar c = 0; c < size; c++) begin : g_col
            if (c == 0) begin : g_lane
                assign a_in[r][c] = input_stream[(size-r)*data_size-1 -: data_size];
            end else begin : g_left
                assign a_in[r][c] = a_reg[r][c-1];
            end

            if (r == 0) begin : g_top
                assign psum_in[r][c] = '0;
            end else begin : g_above
                assign psum_in[r][c] = psum[r-1][c];
            end

            // PE: pass the activation right and add this row's product to the sum heading down.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_reg[r][c] <= '0;
                    psum[r][c]  <= '0;
                end else begin
                    a_reg[r][c] <= a_in[r][c];
                    psum[r][c]  <= psum_in[r][c]
                                   + acc_size'(a_in[r][c]) * acc_size'(weight[r][c]);
                end
            end
        end
    end

    for (genvar c = 0; c < size; c++) begin : g_deskew
        localparam int depth = size - 1 - c;
        if (depth == 0) begin : g_direct
            assign col_out[c] = psum[size-1][c];
        end else begin : g_delay
            logic [acc_size-1:0] dly [depth];

            // Deskew: hold earlier columns back so every column lands in the same cycle.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < depth; i++) begin
                        dly[i] <= '0;
                    end
                end else begin
                    dly[0] <= psum[size-1][c];
                    for (int i = 1; i < depth; i++) begin
                        dly[i] <= dly[i-1];
                    end
                end
            end

            assign col_out[c] = dly[depth-1];
        end
    end

    // Pack the aligned column results; every column already comes straight from a flop.
    always_comb begin
        // NOTE: default first so no path through this block can infer a latch.
        output_stream = '0;
        for (int c = 0; c < size; c++) begin
            output_stream[(size-c)*acc_size-1 -: acc_size] = col_out[c];
        end
    end

    // Valid pipeline: tracks accepted vectors through the array and the deskew stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_pipe <= '0;
        end else begin
            valid_pipe[0] <= vec_accept;
            for (int i = 1; i < vp_depth; i++) begin
                valid_pipe[i] <= valid_pipe[i-1];
            end
        end
    end

endmodule
